// File: rtl/stopwatch_ctl.sv
// MM:SS stopwatch controller: button sync/edge detect, start/pause/lap FSM, BCD time count.
// Optional lap-freeze feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t        state, state_next;
  logic [1:0]    sync_start, sync_lap;
  logic          start_d, lap_d;
  logic [1:0]    settle;
  logic          armed;
  logic          start_ev, lap_ev;
  logic [PW-1:0] presc;
  logic [3:0]    sec0, sec1, min0, min1;
  logic [3:0]    nsec0, nsec1, nmin0, nmin1;
  logic          counting, tick, at_max, show_live;

  // Edges are masked until the synchronizer holds two post-reset samples,
  // so a level already high at reset release never produces an event.
  assign armed    = (settle == 2'd3);
  assign start_ev = sync_start[1] & ~start_d & armed;
  assign lap_ev   = sync_lap[1] & ~lap_d & armed & ~start_ev;

`ifdef STOPWATCH_LAP_EN
  assign counting  = (state == RUN) || (state == LAP);
  assign show_live = !((state == LAP) && (state_next == LAP));
`else
  assign counting  = (state == RUN);
  assign show_live = 1'b1;
`endif

  assign tick   = counting && (presc == PW'(TICK_DIV - 1));
  assign at_max = ({min1, min0, sec1, sec0} == 16'h5959);

  // Next-state logic; start has priority over lap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ev) state_next = RUN;
`ifdef STOPWATCH_LAP_EN
      RUN:     if (start_ev) state_next = PAUSE;
               else if (lap_ev) state_next = LAP;
      LAP:     if (start_ev) state_next = PAUSE;
               else if (lap_ev) state_next = RUN;
`else
      RUN:     if (start_ev) state_next = PAUSE;
`endif
      PAUSE:   if (start_ev) state_next = RUN;
               else if (lap_ev) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cascaded BCD increment of MM:SS.
  always_comb begin
    nsec0 = sec0;
    nsec1 = sec1;
    nmin0 = min0;
    nmin1 = min1;
    if (sec0 == 4'd9) begin
      nsec0 = 4'd0;
      if (sec1 == 4'd5) begin
        nsec1 = 4'd0;
        if (min0 == 4'd9) begin
          nmin0 = 4'd0;
          nmin1 = (min1 == 4'd5) ? 4'd0 : min1 + 4'd1;
        end else begin
          nmin0 = min0 + 4'd1;
        end
      end else begin
        nsec1 = sec1 + 4'd1;
      end
    end else begin
      nsec0 = sec0 + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync_start <= 2'b00;
      sync_lap   <= 2'b00;
      start_d    <= 1'b0;
      lap_d      <= 1'b0;
      settle     <= 2'd0;
      presc      <= '0;
      {min1, min0, sec1, sec0} <= 16'h0000;
      {digit3, digit2, digit1, digit0} <= 16'h0000;
      running    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_next;
      sync_start <= {sync_start[0], btn_start};
      sync_lap   <= {sync_lap[0], btn_lap};
      start_d    <= sync_start[1];
      lap_d      <= sync_lap[1];
      if (!armed) settle <= settle + 2'd1;

      if (state_next == IDLE) begin
        presc <= '0;
        {min1, min0, sec1, sec0} <= 16'h0000;
      end else if (counting) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) {min1, min0, sec1, sec0} <= {nmin1, nmin0, nsec1, nsec0};
      end

      // Digits freeze only while staying in LAP; the RUN->LAP edge captures the live count.
      if (show_live) {digit3, digit2, digit1, digit0} <= {min1, min0, sec1, sec0};

`ifdef STOPWATCH_LAP_EN
      running <= (state_next == RUN) || (state_next == LAP);
`else
      running <= (state_next == RUN);
`endif
      wrap    <= tick && at_max;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Directed self-checking bench for stopwatch_ctl with TICK_DIV=4.
// Lap-freeze scenarios follow STOPWATCH_LAP_EN when it is defined.
module tb_stopwatch_ctl;

  logic        clk = 1'b0;
  logic        rst, btn_start, btn_lap;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic        running, wrap;
  logic [15:0] disp;
  int          checks = 0;
  int          errors = 0;

  assign disp = {digit3, digit2, digit1, digit0};

  stopwatch_ctl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Each step crosses exactly one rising edge; sampling happens on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  // A one-cycle press acts on the state two edges after it is first sampled.
  task automatic press(input logic s, input logic l);
    btn_start = s; btn_lap = l;
    step(1);
    btn_start = 1'b0; btn_lap = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start = 1'b1; btn_lap = 1'b0;
    step(3);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", disp); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    rst = 1'b0;
    step(6);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_level_no_event: running %b expected 0", running); end
    btn_start = 1'b0;
    step(3);
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_after_release: running %b expected 1", running); end
  endtask

  task automatic test_count();
    do_reset();
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_latency: running %b expected 1", running); end
    step(4);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL count_pre_tick: got %h expected 0000", disp); end
    step(1);
    checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL count_1s: got %h expected 0001", disp); end
    step(4);
    checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL count_2s: got %h expected 0002", disp); end
  endtask

  task automatic test_carry();
    do_reset();
    press(1'b1, 1'b0);
    step(40);
    checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL carry_0009: got %h expected 0009", disp); end
    step(1);
    checks++; if (disp !== 16'h0010) begin errors++; $display("FAIL carry_0010: got %h expected 0010", disp); end
    step(199);
    checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL carry_0059: got %h expected 0059", disp); end
    step(1);
    checks++; if (disp !== 16'h0100) begin errors++; $display("FAIL carry_0100: got %h expected 0100", disp); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(1'b1, 1'b0);
    step(14399);
    checks++; if (disp !== 16'h5959) begin errors++; $display("FAIL wrap_5959: got %h expected 5959", disp); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b expected 0", wrap); end
    step(1);
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %b expected 1", wrap); end
    step(1);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %b expected 0", wrap); end
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL wrap_0000: got %h expected 0000", disp); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b expected 1", running); end
  endtask

  task automatic test_pause();
    do_reset();
    btn_start = 1'b1; step(1);
    btn_start = 1'b0; step(1);
    btn_start = 1'b1; step(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_run: running %b expected 1", running); end
    btn_start = 1'b0; step(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_enter: running %b expected 0", running); end
    step(10);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL pause_hold: got %h expected 0000", disp); end
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume: running %b expected 1", running); end
    step(2);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL resume_r2: got %h expected 0000", disp); end
    step(1);
    checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL resume_credit: got %h expected 0001", disp); end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running: got %b expected 0", running); end
    checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL clear_edge_digits: got %h expected 0002", disp); end
    step(1);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clear_digits: got %h expected 0000", disp); end
  endtask

  task automatic test_lap();
    do_reset();
    press(1'b1, 1'b0);
    step(10);
    press(1'b0, 1'b1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %b expected 1", running); end
    checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL lap_capture: got %h expected 0003", disp); end
`ifdef STOPWATCH_LAP_EN
    for (int i = 1; i <= 11; i++) begin
      if (i == 10) btn_lap = 1'b1;
      if (i == 11) btn_lap = 1'b0;
      step(1);
      checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL lap_freeze[%0d]: got %h expected 0003", i, disp); end
    end
    step(1);
    checks++; if (disp !== 16'h0006) begin errors++; $display("FAIL lap_release: got %h expected 0006", disp); end
`else
    step(12);
    checks++; if (disp !== 16'h0006) begin errors++; $display("FAIL lap_ignored: got %h expected 0006", disp); end
`endif
    step(4);
    checks++; if (disp !== 16'h0007) begin errors++; $display("FAIL lap_live: got %h expected 0007", disp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(1'b1, 1'b0);
    step(5);
    press(1'b1, 1'b1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL both_to_pause: running %b expected 0", running); end
    step(8);
    checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL both_hold: got %h expected 0002", disp); end
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL both_resume: running %b expected 1", running); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(1'b1, 1'b0);
    step(10);
`ifdef STOPWATCH_LAP_EN
    press(1'b0, 1'b1);
`else
    step(3);
`endif
    checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL mid_before: got %h expected 0003", disp); end
    rst = 1'b1;
    step(1);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL mid_rst_digits: got %h expected 0000", disp); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_running: got %b expected 0", running); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_wrap: got %b expected 0", wrap); end
    rst = 1'b0;
    step(8);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL mid_idle_after: got %h expected 0000", disp); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_pause();
    test_lap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
